mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32: address width.
REQ-002 The block SHALL have parameter DW, default 32: data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4: consecutive fetch losses that force a fetch grant (range 1..15).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_gnt  out  1  one-cycle pulse: fetch request accepted.
REQ-009 if_rvalid  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-010 if_rdata  out  DW  fetch read data.
REQ-011 d_req  in  1  data request; held with d_we, d_addr, d_wdata, d_mask until d_gnt.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  AW  data address.
REQ-014 d_wdata  in  DW  store data.
REQ-015 d_mask  in  2  access size: 0 = byte, 1 = half, 2 = word.
REQ-016 d_gnt  out  1  one-cycle pulse: data request accepted.
REQ-017 d_rvalid  out  1  one-cycle pulse: data access complete.
REQ-018 d_rdata  out  DW  load data.
REQ-019 mem_req, mem_we, mem_addr, mem_wdata, mem_mask  out  1/1/AW/DW/2  registered request to the shared single-port memory.
REQ-020 mem_rdata  in  DW; mem_ready  in  1  memory completion strobe, rdata valid in the same cycle.

Function
REQ-021 FSM states SHALL be IDLE, BUSY_IF and BUSY_D.
REQ-022 In IDLE with any request, the block SHALL select one winner combinationally, assert its gnt in that cycle, register its fields onto mem_*, and enter BUSY_IF/BUSY_D on the next edge.
REQ-023 Default priority SHALL be data over fetch.
REQ-024 Fetch SHALL win when starve_cnt == STARVE_MAX and if_req = 1.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_MAX, on each d_gnt with if_req = 1.
REQ-026 starve_cnt SHALL clear on if_gnt, or in IDLE when if_req = 0.
REQ-027 In BUSY_x, mem_req SHALL stay 1 with mem_* stable until mem_ready = 1.
REQ-028 On mem_ready = 1, the block SHALL return to IDLE on the next edge and drop mem_req in that same next cycle.
REQ-029 For a load or fetch, x_rdata SHALL capture mem_rdata on the mem_ready edge.
REQ-030 x_rvalid SHALL pulse for exactly one cycle in the cycle after mem_ready.
REQ-031 A store SHALL pulse d_rvalid with d_rdata unchanged.
REQ-032 x_rdata SHALL hold its value until the next completion of the same port.
REQ-033 New grants SHALL be possible in the IDLE cycle that carries an rvalid pulse, giving a minimum of 2 cycles per transaction with a 1-cycle memory.
REQ-034 Requests arriving in BUSY SHALL wait without a grant.
REQ-035 A request dropped before its grant SHALL be withdrawn with no side effect.
REQ-036 mem_ready in IDLE SHALL be ignored.
REQ-037 At most one gnt, and at most one rvalid, SHALL be asserted per cycle.

Reset
REQ-038 rst = 0 SHALL asynchronously force IDLE, clear starve_cnt, and drive all outputs to 0, including rdata and mem_*.
REQ-039 A transaction in flight at reset SHALL be abandoned with no rvalid.
REQ-040 The first grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-041 With macro MEM_ARB_ROUND_ROBIN_EN defined, priority SHALL be round-robin: the port granted last has lowest priority on the next contested grant, and the initial last-granted after reset is fetch, so data wins the first tie.
REQ-042 With MEM_ARB_ROUND_ROBIN_EN defined, starve_cnt and STARVE_MAX SHALL be absent or unused.
REQ-043 Without MEM_ARB_ROUND_ROBIN_EN, REQ-023 to REQ-026 SHALL apply.

Verification
REQ-044 Reset then fetch-only: if_req = 1, if_addr = 0x0, mem_ready 1 cycle after mem_req, mem_rdata = 0x00500093 -> if_gnt in cycle 0, mem_req cycles 1-2, if_rvalid cycle 3 with if_rdata = 0x00500093.
REQ-045 Simultaneous if_req and d_req, load d_addr = 0x100 -> d_gnt first; fetch granted in the IDLE after d_rvalid; d_rdata = mem_rdata of the load.
REQ-046 d_req held continuously, if_req held, STARVE_MAX = 4 -> exactly 4 d_gnt, then if_gnt, then starve_cnt = 0.
REQ-047 Store d_we = 1, d_addr = 0x20, d_wdata = 0xDEADBEEF, d_mask = 2, mem_ready delayed 5 cycles -> mem_* stable for 6 cycles; d_rvalid pulses once; d_rdata unchanged.
REQ-048 rst asserted mid-BUSY_D -> outputs 0 immediately; no d_rvalid; IDLE after release.
REQ-049 With MEM_ARB_ROUND_ROBIN_EN, both ports requesting continuously -> grants alternate D, IF, D, IF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory port of mem_arbiter.
// Latency: none, wiring only.
// Backpressure: req/gnt per requester; mem_ready completes the memory side.
//
// Port summary:
//   if_*  : fetch requester (req/addr in, gnt/rvalid/rdata out of arbiter)
//   d_*   : data requester (req/we/addr/wdata/mask in, gnt/rvalid/rdata out)
//   mem_* : single-port memory (registered request out, rdata/ready back in)
// Modports: slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_mask;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_mask;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_mask,
    input  mem_rdata, mem_ready,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_mask,
    output mem_rdata, mem_ready,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Latency: gnt same cycle as req in IDLE; mem_req next cycle; rvalid one cycle after mem_ready.
// Backpressure: requests hold until gnt; one transaction in flight, others wait in BUSY.
//
// Ports: clk (sole clock), rst (async active-low), bus (mem_arbiter_if.slave).
// Priority: data over fetch, with fetch forced after STARVE_MAX consecutive
// data wins while fetch waits. Defining MEM_ARB_ROUND_ROBIN_EN replaces this
// with round-robin (last granted port loses the next tie; fetch counts as
// last granted after reset, so data wins the first tie).
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_mask_q, mem_mask_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_win, d_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          last_if_q, last_if_d;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0]    starve_cnt_q, starve_cnt_d;
`endif

  // Winner selection is purely combinational so the grant lands in the
  // same IDLE cycle the request is seen.
  always_comb begin
    d_win  = 1'b0;
    if_win = 1'b0;
    if (state_q == IDLE) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      d_win = bus.d_req && (!bus.if_req || last_if_q);
`else
      d_win = bus.d_req && !(bus.if_req && (starve_cnt_q == STARVE_LIM));
`endif
      if_win = bus.if_req && !d_win;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_if_d   = last_if_q;
`else
    starve_cnt_d = starve_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // mem_ready is deliberately not looked at here.
        if (d_win) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_mask_d  = bus.d_mask;
        end else if (if_win) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_mask_d  = 2'd2;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (d_win) begin
          last_if_d = 1'b0;
        end else if (if_win) begin
          last_if_d = 1'b1;
        end
`else
        // Count only data wins that actually made fetch wait.
        if (if_win || !bus.if_req) begin
          starve_cnt_d = '0;
        end else if (d_win && (starve_cnt_q != STARVE_LIM)) begin
          starve_cnt_d = starve_cnt_q + 4'd1;
        end
`endif
      end

      BUSY_IF: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
        end
      end

      BUSY_D: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          d_rvalid_d = 1'b1;
          // Stores complete without disturbing the last load data.
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_mask_q   <= 2'd0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_if_q    <= 1'b1;
`else
      starve_cnt_q <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_mask_q   <= mem_mask_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_if_q    <= last_if_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Grants are combinational; gate them with rst so nothing leaks out
  // while reset is held with requests pending.
  assign bus.if_gnt    = if_win & rst;
  assign bus.d_gnt     = d_win & rst;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_mask  = mem_mask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, memory model, monitor.
// Latency: n/a.
// Backpressure: requesters hold req until gnt; memory answers after mem_lat cycles.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
  } gnt_t;
  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0)   return 32'h0050_0093;
    if (a == 32'h100) return 32'hCAFE_F00D;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Pin drive: automatic drivers or manual (directed) values.
  logic        drv_en;
  logic        m_if_req, m_d_req, m_d_we, g_if_req, g_d_req, g_d_we;
  logic [31:0] m_if_addr, m_d_addr, m_d_wdata, g_if_addr, g_d_addr, g_d_wdata;
  logic [1:0]  m_d_mask, g_d_mask;
  logic        mm_ready;
  logic [31:0] mm_rdata;

  assign bus.if_req    = drv_en ? g_if_req  : m_if_req;
  assign bus.if_addr   = drv_en ? g_if_addr : m_if_addr;
  assign bus.d_req     = drv_en ? g_d_req   : m_d_req;
  assign bus.d_we      = drv_en ? g_d_we    : m_d_we;
  assign bus.d_addr    = drv_en ? g_d_addr  : m_d_addr;
  assign bus.d_wdata   = drv_en ? g_d_wdata : m_d_wdata;
  assign bus.d_mask    = drv_en ? g_d_mask  : m_d_mask;
  assign bus.mem_ready = mm_ready;
  assign bus.mem_rdata = mm_rdata;

  // Memory: ready in the (mem_lat+1)-th cycle of mem_req; stray forces ready while idle.
  int mem_lat = 1;
  bit stray = 1'b0;
  initial begin
    int mcnt;
    mcnt = 0; mm_ready = 1'b0; mm_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        mcnt++;
        mm_ready = (mcnt == mem_lat + 1);
        mm_rdata = mm_ready ? mem_fn(bus.mem_addr) : 32'h0BAD_0BAD;
      end else begin
        mcnt = 0;
        mm_ready = stray;
        mm_rdata = stray ? 32'hFFFF_FFFF : 32'h0;
      end
    end
  end

  // Scoreboard queues and expectation helpers.
  gnt_t        exp_gnt_q[$];
  rsp_t        exp_rsp_q[$];
  gnt_t        d_items[$];
  logic [31:0] if_items[$];
  logic [31:0] model_d_rdata = '0;
  logic [31:0] model_if_rdata = '0;

  task automatic exp_fetch(input logic [31:0] a, input bit with_rsp);
    gnt_t g; rsp_t r;
    g.is_d = 1'b0; g.we = 1'b0; g.addr = a; g.wdata = '0; g.mask = 2'd2;
    exp_gnt_q.push_back(g);
    if (with_rsp) begin
      model_if_rdata = mem_fn(a);
      r.is_d = 1'b0; r.rdata = model_if_rdata;
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic exp_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] m, input bit with_rsp);
    gnt_t g; rsp_t r;
    g.is_d = 1'b1; g.we = we; g.addr = a; g.wdata = wd; g.mask = m;
    exp_gnt_q.push_back(g);
    if (with_rsp) begin
      if (!we) model_d_rdata = mem_fn(a);
      r.is_d = 1'b1; r.rdata = model_d_rdata;
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic queue_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m);
    gnt_t g;
    g.is_d = 1'b1; g.we = we; g.addr = a; g.wdata = wd; g.mask = m;
    d_items.push_back(g);
  endtask

  // Requester drivers: hold req until gnt, then present the next item at once.
  logic d_gnt_seen = 1'b0;
  logic if_gnt_seen = 1'b0;
  initial begin
    int d_wait;
    gnt_t it;
    d_wait = 0; g_d_req = 1'b0; g_d_we = 1'b0; g_d_addr = '0; g_d_wdata = '0; g_d_mask = 2'd0;
    forever begin
      @(posedge clk); #1;
      if (drv_en) begin
        if (g_d_req && d_gnt_seen) g_d_req = 1'b0;
        if (!g_d_req && d_items.size() > 0) begin
          it = d_items.pop_front();
          g_d_req = 1'b1; g_d_we = it.we; g_d_addr = it.addr; g_d_wdata = it.wdata; g_d_mask = it.mask;
          d_gnt_seen = 1'b0; d_wait = 0;
        end else if (g_d_req) begin
          d_wait++;
          if (d_wait > 400) begin check("d_grant_timeout", 32'(d_wait), 0); g_d_req = 1'b0; end
        end
      end
    end
  end

  initial begin
    int if_wait;
    if_wait = 0; g_if_req = 1'b0; g_if_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (drv_en) begin
        if (g_if_req && if_gnt_seen) g_if_req = 1'b0;
        if (!g_if_req && if_items.size() > 0) begin
          g_if_addr = if_items.pop_front();
          g_if_req = 1'b1; if_gnt_seen = 1'b0; if_wait = 0;
        end else if (g_if_req) begin
          if_wait++;
          if (if_wait > 400) begin check("if_grant_timeout", 32'(if_wait), 0); g_if_req = 1'b0; end
        end
      end
    end
  end

  // Monitor: pops and compares on every gnt/rvalid, checks mem_* and stability.
  int          gnt_cyc_log[$];
  int          last_d_rv_cyc = -1, last_if_gnt_cyc = -2;
  int          burst_len = 0, last_burst_len = 0;
  bit          burst_ok = 1'b1, last_burst_ok = 1'b0;
  bit          chk_mem_next = 1'b0, chk_starve_next = 1'b0;
  gnt_t        pend;
  logic [31:0] snap_addr, snap_wdata;
  logic [1:0]  snap_mask;
  logic        snap_we;

  initial begin
    gnt_t g; rsp_t r;
    forever begin
      @(negedge clk);
      if (chk_mem_next) begin
        chk_mem_next = 1'b0;
        check("mem_req_after_gnt", 32'(bus.mem_req), 1);
        check("mem_addr", bus.mem_addr, pend.addr);
        check("mem_we", 32'(bus.mem_we), 32'(pend.we));
        if (pend.is_d) begin
          check("mem_wdata", bus.mem_wdata, pend.wdata);
          check("mem_mask", 32'(bus.mem_mask), 32'(pend.mask));
        end
      end
`ifndef MEM_ARB_ROUND_ROBIN_EN
      if (chk_starve_next) begin
        chk_starve_next = 1'b0;
        check("starve_cnt_after_if_gnt", 32'(dut.starve_cnt_q), 0);
      end
`endif
      if (bus.if_gnt || bus.d_gnt) begin
        check("one_gnt_per_cycle", 32'(bus.if_gnt && bus.d_gnt), 0);
        gnt_cyc_log.push_back(cyc);
        if (bus.d_gnt) d_gnt_seen = 1'b1;
        else begin if_gnt_seen = 1'b1; last_if_gnt_cyc = cyc; chk_starve_next = 1'b1; end
        if (exp_gnt_q.size() == 0) check("unexpected_gnt", 32'({bus.if_gnt, bus.d_gnt}), 0);
        else begin
          g = exp_gnt_q.pop_front();
          check("gnt_port_is_d", 32'(bus.d_gnt), 32'(g.is_d));
          pend = g; chk_mem_next = 1'b1;
        end
      end
      if (bus.if_rvalid || bus.d_rvalid) begin
        check("one_rvalid_per_cycle", 32'(bus.if_rvalid && bus.d_rvalid), 0);
        if (bus.d_rvalid) last_d_rv_cyc = cyc;
        if (exp_rsp_q.size() == 0) check("unexpected_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 0);
        else begin
          r = exp_rsp_q.pop_front();
          check("rvalid_port_is_d", 32'(bus.d_rvalid), 32'(r.is_d));
          check("rdata", bus.d_rvalid ? bus.d_rdata : bus.if_rdata, r.rdata);
        end
      end
      if (bus.mem_req) begin
        if (burst_len == 0) begin
          snap_addr = bus.mem_addr; snap_wdata = bus.mem_wdata; snap_mask = bus.mem_mask; snap_we = bus.mem_we;
        end else if (bus.mem_addr !== snap_addr || bus.mem_wdata !== snap_wdata ||
                     bus.mem_mask !== snap_mask || bus.mem_we !== snap_we) begin
          burst_ok = 1'b0;
        end
        burst_len++;
      end else if (burst_len != 0) begin
        last_burst_len = burst_len; last_burst_ok = burst_ok; burst_len = 0; burst_ok = 1'b1;
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 500 && !(exp_gnt_q.size() == 0 && exp_rsp_q.size() == 0 && d_items.size() == 0 &&
                        if_items.size() == 0 && !bus.if_req && !bus.d_req && !bus.mem_req)) begin
      @(negedge clk); n++;
    end
    check({name, "_completion_timeout"}, 32'(n >= 500), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"}, 32'(bus.if_gnt), 0);
    check({tag, "_d_gnt"}, 32'(bus.d_gnt), 0);
    check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 0);
    check({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 0);
    check({tag, "_if_rdata"}, bus.if_rdata, 0);
    check({tag, "_d_rdata"}, bus.d_rdata, 0);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_mem_mask"}, 32'(bus.mem_mask), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    drv_en = 1'b0;
    m_if_req = 1'b1; m_if_addr = 32'h0;
    m_d_req = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h100; m_d_wdata = '0; m_d_mask = 2'd2;

    // Reset with both requests pending: everything must read 0.
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Fetch-only from reset release: gnt c0, mem_req c1-c2, rvalid c3.
    @(posedge clk); #1;
    m_d_req = 1'b0; rst = 1'b1;
    exp_fetch(32'h0, 1'b1);
    @(negedge clk); check("c0_if_gnt", 32'(bus.if_gnt), 1); check("c0_mem_req", 32'(bus.mem_req), 0);
    @(posedge clk); #1; m_if_req = 1'b0;
    @(negedge clk); check("c1_mem_req", 32'(bus.mem_req), 1);
    @(negedge clk); check("c2_mem_req", 32'(bus.mem_req), 1); check("c2_if_rvalid", 32'(bus.if_rvalid), 0);
    @(negedge clk); check("c3_mem_req", 32'(bus.mem_req), 0); check("c3_if_rvalid", 32'(bus.if_rvalid), 1);
    check("c3_if_rdata", bus.if_rdata, 32'h0050_0093);
    @(negedge clk); check("c4_if_rvalid", 32'(bus.if_rvalid), 0);

    // Simultaneous load and fetch: data first, fetch in the load's rvalid cycle.
    drv_en = 1'b1;
    queue_d(1'b0, 32'h100, 32'h0, 2'd2);
    if_items.push_back(32'h4);
    exp_data(1'b0, 32'h100, 32'h0, 2'd2, 1'b1);
    exp_fetch(32'h4, 1'b1);
    wait_done("tie");
    check("if_gnt_in_d_rvalid_cycle", 32'(last_if_gnt_cyc), 32'(last_d_rv_cyc));

    // Continuous contention with a 0-latency memory.
    mem_lat = 0;
    gnt_cyc_log.delete();
    for (int i = 0; i < 6; i++) queue_d(1'b0, 32'h200 + 32'(4 * i), 32'h0, 2'd2);
    if_items.push_back(32'h40);
    if_items.push_back(32'h44);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_data(1'b0, 32'h200, 32'h0, 2'd2, 1'b1);
    exp_fetch(32'h40, 1'b1);
    exp_data(1'b0, 32'h204, 32'h0, 2'd2, 1'b1);
    exp_fetch(32'h44, 1'b1);
    for (int i = 2; i < 6; i++) exp_data(1'b0, 32'h200 + 32'(4 * i), 32'h0, 2'd2, 1'b1);
`else
    for (int i = 0; i < 4; i++) exp_data(1'b0, 32'h200 + 32'(4 * i), 32'h0, 2'd2, 1'b1);
    exp_fetch(32'h40, 1'b1);
    exp_data(1'b0, 32'h210, 32'h0, 2'd2, 1'b1);
    exp_data(1'b0, 32'h214, 32'h0, 2'd2, 1'b1);
    exp_fetch(32'h44, 1'b1);
`endif
    wait_done("starve");
    check("grant_count", 32'(gnt_cyc_log.size()), 8);
    if (gnt_cyc_log.size() >= 5) begin
      check("back_to_back_gap_0_1", 32'(gnt_cyc_log[1] - gnt_cyc_log[0]), 2);
      check("back_to_back_gap_3_4", 32'(gnt_cyc_log[4] - gnt_cyc_log[3]), 2);
    end

    // Store with a slow memory: mem_* stable 6 cycles, d_rdata untouched.
    mem_lat = 5;
    queue_d(1'b1, 32'h20, 32'hDEAD_BEEF, 2'd2);
    exp_data(1'b1, 32'h20, 32'hDEAD_BEEF, 2'd2, 1'b1);
    wait_done("store");
    check("store_mem_req_cycles", 32'(last_burst_len), 6);
    check("store_mem_stable", 32'(last_burst_ok), 1);
    check("store_d_rdata_hold", bus.d_rdata, model_d_rdata);

    // Stray mem_ready while idle must be ignored.
    @(posedge clk); #1; stray = 1'b1;
    @(posedge clk); #1; stray = 1'b0;
    @(negedge clk);
    check("stray_if_rvalid", 32'(bus.if_rvalid), 0);
    check("stray_d_rvalid", 32'(bus.d_rvalid), 0);
    check("stray_mem_req", 32'(bus.mem_req), 0);
    repeat (2) @(negedge clk);

    // Request arriving while busy waits, then is withdrawn before any grant.
    drv_en = 1'b0;
    m_if_req = 1'b0; m_d_req = 1'b0;
    mem_lat = 4;
    @(posedge clk); #1; m_if_req = 1'b1; m_if_addr = 32'h80;
    exp_fetch(32'h80, 1'b1);
    @(negedge clk); check("busy_if_gnt", 32'(bus.if_gnt), 1);
    @(posedge clk); #1; m_if_req = 1'b0; m_d_req = 1'b1; m_d_we = 1'b0; m_d_addr = 32'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("busy_no_d_gnt", 32'(bus.d_gnt), 0);
    end
    @(posedge clk); #1; m_d_req = 1'b0;
    wait_done("withdraw");
    check("withdraw_d_rdata_hold", bus.d_rdata, model_d_rdata);

    // Reset in the middle of a load: immediate zeros, no rvalid, grant right after release.
    mem_lat = 8;
    @(posedge clk); #1; m_d_req = 1'b1; m_d_addr = 32'h400;
    exp_data(1'b0, 32'h400, 32'h0, 2'd2, 1'b0);
    @(negedge clk); check("pre_reset_d_gnt", 32'(bus.d_gnt), 1);
    @(posedge clk); #1; m_d_req = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    model_d_rdata = '0; model_if_rdata = '0;
    repeat (2) @(posedge clk);
    #1; mem_lat = 1; rst = 1'b1; m_if_req = 1'b1; m_if_addr = 32'h8;
    exp_fetch(32'h8, 1'b1);
    @(negedge clk); check("first_cycle_after_reset_if_gnt", 32'(bus.if_gnt), 1);
    @(posedge clk); #1; m_if_req = 1'b0;
    wait_done("post_reset");
    check("post_reset_d_rdata", bus.d_rdata, 0);

    check("exp_gnt_q_empty", 32'(exp_gnt_q.size()), 0);
    check("exp_rsp_q_empty", 32'(exp_rsp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
